// File: rtl/mlp_load_sequencer.sv
// mlp_load_sequencer: parses one layer header from the stream FIFO, loads inputs
// and weights into their buffers, then starts the MLP core and waits for it.
module mlp_load_sequencer #(
    parameter int DATA_W      = 32,
    parameter int MAX_INPUTS  = 256,
    parameter int MAX_WEIGHTS = 65536,
    parameter int IN_ADDR_W   = 8,
    parameter int W_ADDR_W    = 16
) (
    input  logic                 S_AXIS_ACLK,
    input  logic                 S_AXIS_ARESETN,
    input  logic                 fifo_valid,
    input  logic [DATA_W-1:0]    fifo_data,
    output logic                 fifo_read,
    output logic                 in_wr_en,
    output logic [IN_ADDR_W-1:0] in_wr_addr,
    output logic [DATA_W-1:0]    in_wr_data,
    output logic                 w_wr_en,
    output logic [W_ADDR_W-1:0]  w_wr_addr,
    output logic [DATA_W-1:0]    w_wr_data,
    output logic [15:0]          cfg_num_inputs,
    output logic [15:0]          cfg_num_neurons,
    output logic                 core_start,
    input  logic                 core_done,
    output logic                 busy,
    output logic                 error,
    input  logic                 err_clr
);
    typedef enum logic [2:0] {HEADER, INPUTS, WEIGHTS, START, RUN, ERR} state_t;

    state_t                state_q, state_d;
    logic [IN_ADDR_W-1:0]  in_cnt_q, in_cnt_d, in_last_q, in_last_d, in_addr_q, in_addr_d;
    logic [W_ADDR_W-1:0]   w_cnt_q, w_cnt_d, w_last_q, w_last_d, w_addr_q, w_addr_d;
    logic [DATA_W-1:0]     in_data_q, in_data_d, w_data_q, w_data_d;
    logic [15:0]           cfg_n_q, cfg_n_d, cfg_m_q, cfg_m_d;
    logic                  in_we_q, in_we_d, w_we_q, w_we_d, start_q, start_d, err_q, err_d;
    logic [15:0]           hdr_n, hdr_m;
    logic [32:0]           w_total;
    logic                  pop, hdr_bad;

    assign hdr_n   = fifo_data[15:0];
    assign hdr_m   = fifo_data[31:16];
    // The bias of each neuron is stored as one extra weight word.
    assign w_total = 33'(hdr_m) * (33'(hdr_n) + 33'd1);
    assign hdr_bad = (hdr_n == 16'd0) || (hdr_m == 16'd0) || (int'(hdr_n) > MAX_INPUTS) ||
                     (w_total > 33'(MAX_WEIGHTS));

    assign fifo_read       = fifo_valid && (state_q == HEADER || state_q == INPUTS || state_q == WEIGHTS);
    assign pop             = fifo_valid && fifo_read;
    assign busy            = state_q != HEADER;
    assign in_wr_en        = in_we_q;
    assign in_wr_addr      = in_addr_q;
    assign in_wr_data      = in_data_q;
    assign w_wr_en         = w_we_q;
    assign w_wr_addr       = w_addr_q;
    assign w_wr_data       = w_data_q;
    assign cfg_num_inputs  = cfg_n_q;
    assign cfg_num_neurons = cfg_m_q;
    assign core_start      = start_q;
    assign error           = err_q;

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        in_last_d = in_last_q;
        w_cnt_d   = w_cnt_q;
        w_last_d  = w_last_q;
        cfg_n_d   = cfg_n_q;
        cfg_m_d   = cfg_m_q;
        in_we_d   = 1'b0;
        in_addr_d = in_addr_q;
        in_data_d = in_data_q;
        w_we_d    = 1'b0;
        w_addr_d  = w_addr_q;
        w_data_d  = w_data_q;
        unique case (state_q)
            HEADER: if (pop) begin
                cfg_n_d   = hdr_n;
                cfg_m_d   = hdr_m;
                // Last indices fit the address widths whenever the header is legal.
                in_last_d = IN_ADDR_W'(hdr_n - 16'd1);
                w_last_d  = W_ADDR_W'(w_total - 33'd1);
                in_cnt_d  = '0;
                w_cnt_d   = '0;
                state_d   = hdr_bad ? ERR : INPUTS;
            end
            INPUTS: if (pop) begin
                in_we_d   = 1'b1;
                in_addr_d = in_cnt_q;
                in_data_d = fifo_data;
                in_cnt_d  = in_cnt_q + IN_ADDR_W'(1);
                if (in_cnt_q == in_last_q) begin
                    state_d = WEIGHTS;
                    w_cnt_d = '0;
                end
            end
            WEIGHTS: if (pop) begin
                w_we_d   = 1'b1;
                w_addr_d = w_cnt_q;
                w_data_d = fifo_data;
                w_cnt_d  = w_cnt_q + W_ADDR_W'(1);
                if (w_cnt_q == w_last_q) state_d = START;
            end
            START:   state_d = RUN;
            RUN:     if (core_done) state_d = HEADER;
            ERR:     if (err_clr) state_d = HEADER;
            default: state_d = HEADER;
        endcase
        start_d = state_d == START;
        err_d   = state_d == ERR;
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state_q   <= HEADER;
            in_cnt_q  <= '0;
            in_last_q <= '0;
            w_cnt_q   <= '0;
            w_last_q  <= '0;
            cfg_n_q   <= '0;
            cfg_m_q   <= '0;
            in_we_q   <= 1'b0;
            in_addr_q <= '0;
            in_data_q <= '0;
            w_we_q    <= 1'b0;
            w_addr_q  <= '0;
            w_data_q  <= '0;
            start_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            in_last_q <= in_last_d;
            w_cnt_q   <= w_cnt_d;
            w_last_q  <= w_last_d;
            cfg_n_q   <= cfg_n_d;
            cfg_m_q   <= cfg_m_d;
            in_we_q   <= in_we_d;
            in_addr_q <= in_addr_d;
            in_data_q <= in_data_d;
            w_we_q    <= w_we_d;
            w_addr_q  <= w_addr_d;
            w_data_q  <= w_data_d;
            start_q   <= start_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_mlp_load_sequencer.sv
// tb_mlp_load_sequencer: drives layer jobs from a queue-based FIFO model and checks
// buffer writes, start/done handshake, header errors and mid-job reset.
module tb_mlp_load_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_valid = 1'b0;
    logic [31:0] fifo_data = '0;
    logic        fifo_read;
    logic        in_wr_en, w_wr_en, core_start, busy, error;
    logic [7:0]  in_wr_addr;
    logic [15:0] w_wr_addr, cfg_num_inputs, cfg_num_neurons;
    logic [31:0] in_wr_data, w_wr_data;
    logic        core_done = 1'b0;
    logic        err_clr = 1'b0;

    mlp_load_sequencer dut (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .fifo_valid(fifo_valid), .fifo_data(fifo_data),
        .fifo_read(fifo_read), .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .in_wr_data(in_wr_data),
        .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
        .cfg_num_inputs(cfg_num_inputs), .cfg_num_neurons(cfg_num_neurons),
        .core_start(core_start), .core_done(core_done), .busy(busy), .error(error), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    logic [31:0] fifo_q[$], preset[$];
    int          in_a[$], w_a[$];
    logic [31:0] in_d[$], w_d[$];
    int  cyc = 0, last_cons = 0, start_cyc = 0, starts = 0, lat_err = 0, bad_read = 0;
    int  gap_mode = 0;
    bit  tog = 1'b0, cons_prev = 1'b0;

    task automatic refresh();
        bit gate;
        gate = (gap_mode == 0) || (gap_mode == 1 && tog) || (gap_mode == 2 && $urandom_range(99) < 60);
        fifo_valid = gate && fifo_q.size() > 0;
        fifo_data  = fifo_q.size() > 0 ? fifo_q[0] : 32'h0;
    endtask

    task automatic clear_logs();
        in_a.delete(); in_d.delete(); w_a.delete(); w_d.delete();
        starts = 0; lat_err = 0; bad_read = 0;
    endtask

    // One clock: observe at negedge, pop consumed word and change inputs after posedge.
    task automatic tick();
        bit cons;
        @(negedge clk);
        cyc++;
        if (in_wr_en) begin in_a.push_back(int'(in_wr_addr)); in_d.push_back(in_wr_data); end
        if (w_wr_en) begin w_a.push_back(int'(w_wr_addr)); w_d.push_back(w_wr_data); end
        if ((in_wr_en || w_wr_en) && !cons_prev) lat_err++;
        if (core_start) begin starts++; start_cyc = cyc; end
        if (fifo_read && !fifo_valid) bad_read++;
        cons = fifo_valid && fifo_read;
        if (cons) last_cons = cyc;
        @(posedge clk);
        #1;
        cons_prev = cons;
        if (cons) void'(fifo_q.pop_front());
        tog = ~tog;
        core_done = 1'b0;
        err_clr = 1'b0;
        refresh();
    endtask

    task automatic run_job(input int n, input int m, input int mode, input bit done_early, input bit skip_hdr);
        int w, budget, bad;
        bit pulsed;
        logic [31:0] ins[$], ws[$];
        w = m * (n + 1);
        pulsed = 1'b0;
        clear_logs();
        gap_mode = mode;
        if (!skip_hdr) fifo_q.push_back({16'(m), 16'(n)});
        for (int i = 0; i < n + w; i++) begin
            logic [31:0] v;
            v = preset.size() > 0 ? preset.pop_front() : $urandom;
            if (i < n) ins.push_back(v); else ws.push_back(v);
            fifo_q.push_back(v);
        end
        refresh();
        budget = (1 + n + w) * 4 + 20;
        while (starts == 0 && budget > 0) begin
            if (done_early && !pulsed && in_a.size() > 0) begin core_done = 1'b1; pulsed = 1'b1; end
            if (mode == 2 && $urandom_range(3) == 0) err_clr = 1'b1;
            tick();
            budget--;
        end
        tests++;
        if (starts != 1) begin fails++; $display("FAIL job_start n=%0d m=%0d: got %0d start pulses, want 1", n, m, starts); end
        bad = 0;
        for (int i = 0; i < in_a.size() && i < n; i++) if (in_a[i] != i || in_d[i] !== ins[i]) bad++;
        tests++;
        if (in_a.size() != n || bad != 0) begin
            fails++; $display("FAIL in_writes n=%0d: got %0d writes (%0d wrong), want %0d", n, in_a.size(), bad, n);
        end
        bad = 0;
        for (int i = 0; i < w_a.size() && i < w; i++) if (w_a[i] != i || w_d[i] !== ws[i]) bad++;
        tests++;
        if (w_a.size() != w || bad != 0) begin
            fails++; $display("FAIL w_writes n=%0d m=%0d: got %0d writes (%0d wrong), want %0d", n, m, w_a.size(), bad, w);
        end
        tests++;
        if (start_cyc != last_cons + 1) begin
            fails++; $display("FAIL start_timing: start at cycle %0d, want %0d", start_cyc, last_cons + 1);
        end
        tests++;
        if (cfg_num_inputs !== 16'(n) || cfg_num_neurons !== 16'(m)) begin
            fails++; $display("FAIL cfg: got %0d/%0d, want %0d/%0d", cfg_num_inputs, cfg_num_neurons, n, m);
        end
        tests++;
        if (lat_err != 0 || bad_read != 0) begin
            fails++; $display("FAIL write_latency: %0d writes without prior pop, %0d reads without valid, want 0/0", lat_err, bad_read);
        end
        gap_mode = 0;
        fifo_q.push_back(32'hDEAD_BEEF);
        refresh();
        bad = 0;
        repeat (3) begin
            tick();
            if (fifo_read !== 1'b0 || fifo_valid !== 1'b1 || busy !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0 || starts != 1 || fifo_q.size() != 1) begin
            fails++; $display("FAIL run_hold: %0d bad cycles, %0d starts, %0d words left, want 0/1/1", bad, starts, fifo_q.size());
        end
        fifo_q.delete();
        refresh();
        core_done = 1'b1;
        tick();
        tests++;
        if (busy !== 1'b0 || cfg_num_inputs !== 16'(n) || cfg_num_neurons !== 16'(m)) begin
            fails++; $display("FAIL done: busy=%0b cfg=%0d/%0d, want busy=0 cfg=%0d/%0d", busy, cfg_num_inputs, cfg_num_neurons, n, m);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        tests++;
        if ({in_wr_en, in_wr_addr, in_wr_data, w_wr_en, w_wr_addr, w_wr_data, cfg_num_inputs,
             cfg_num_neurons, core_start, busy, error, fifo_read} !== '0) begin
            fails++; $display("FAIL reset_outputs: some output nonzero, want all 0");
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tick();
        tests++;
        if (busy !== 1'b0 || error !== 1'b0) begin
            fails++; $display("FAIL reset_idle: busy=%0b error=%0b, want 0/0", busy, error);
        end
    endtask

    task automatic test_basic();
        preset = '{32'h3, 32'hE, 32'h19, 32'h24, 32'h2F};
        run_job(2, 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_gaps();
        preset = '{32'h3, 32'hE, 32'h19, 32'h24, 32'h2F};
        run_job(2, 1, 1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) run_job($urandom_range(1, 8), $urandom_range(1, 6), 2, 1'b0, 1'b0);
        run_job(256, 1, 2, 1'b0, 1'b0);
    endtask

    task automatic test_err_hdr(input logic [31:0] hdr);
        int bad;
        clear_logs();
        gap_mode = 0;
        fifo_q.delete();
        fifo_q.push_back(hdr);
        fifo_q.push_back({16'd1, 16'd1});
        refresh();
        tick();
        tests++;
        if (error !== 1'b1 || busy !== 1'b1) begin
            fails++; $display("FAIL err_flag hdr=%h: error=%0b busy=%0b, want 1/1", hdr, error, busy);
        end
        bad = 0;
        repeat (3) begin
            core_done = 1'b1;
            tick();
            if (fifo_read !== 1'b0 || fifo_valid !== 1'b1 || error !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0 || in_a.size() != 0 || w_a.size() != 0 || fifo_q.size() != 1) begin
            fails++; $display("FAIL err_hold hdr=%h: %0d bad cycles, %0d/%0d writes, %0d words, want 0/0/0/1", hdr, bad, in_a.size(), w_a.size(), fifo_q.size());
        end
        err_clr = 1'b1;
        tick();
        tests++;
        if (error !== 1'b0 || busy !== 1'b0 || fifo_read !== 1'b1) begin
            fails++; $display("FAIL err_clr hdr=%h: error=%0b busy=%0b read=%0b, want 0/0/1", hdr, error, busy, fifo_read);
        end
        run_job(1, 1, 0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int budget;
        clear_logs();
        gap_mode = 0;
        fifo_q = '{32'h0001_0002, 32'h3, 32'hE, 32'h19, 32'h24, 32'h2F};
        refresh();
        budget = 30;
        while (w_a.size() == 0 && budget > 0) begin tick(); budget--; end
        tests++;
        if (w_a.size() != 1) begin fails++; $display("FAIL reset_mid_setup: got %0d weight writes, want 1", w_a.size()); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({in_wr_en, in_wr_addr, in_wr_data, w_wr_en, w_wr_addr, w_wr_data, cfg_num_inputs,
             cfg_num_neurons, core_start, busy, error} !== '0) begin
            fails++; $display("FAIL reset_mid_async: cfg=%0d/%0d busy=%0b waddr=%0d, want all 0", cfg_num_inputs, cfg_num_neurons, busy, w_wr_addr);
        end
        fifo_q.delete();
        refresh();
        cons_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_job(1, 2, 0, 1'b0, 1'b0);
    endtask

    task automatic test_done_in_inputs();
        run_job(4, 2, 0, 1'b1, 1'b0);
        run_job(3, 3, 1, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_err_hdr(32'h0001_0000);
        test_err_hdr({16'd1, 16'd257});
        test_err_hdr(32'h0000_0005);
        test_err_hdr({16'd257, 16'd255});
        test_reset_mid();
        test_done_in_inputs();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, %0d tests run", tests);
        $fatal(1);
    end
endmodule
